vga_frame_sequencer: RTL and testbench
======================================

// Module: vga_frame_sequencer
// PURPOSE
//  Owns VGA 640x480@60 timing on the 25 MHz pixel clock. Sequences the horizontal and
//  vertical counters, decodes sync/blanking/video_on and emits line/frame strobes.
//  Schedules game-logic access to shared sprite/frame state via a req/grant window that
//  is open only during vertical blanking, so state never changes mid-scan.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (H_TOTAL=800)
//  V_ACTIVE 480 visible lines/frame;  V_FP 10;  V_SYNC 2;   V_BP 33  (V_TOTAL=525)
//  SYNC_POL   0  sync asserted level (0 = active-low)
//  GUARD_LINES 2 blanking lines before frame end where no grant may be held
// PORTS
//  clk_25Mhz    in   1   pixel clock, all logic on rising edge
//  d_reset_n    in   1   asynchronous active-low reset
//  run          in   1   1 = timing advances; 0 = freeze counters
//  upd_req      in   1   game logic requests an update window (level)
//  upd_done     in   1   game logic finished update (1-cycle pulse while granted)
//  h_count      out  16  horizontal position 0..H_TOTAL-1
//  v_count      out  16  vertical position 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, level SYNC_POL when asserted
//  vsync        out  1   vertical sync, level SYNC_POL when asserted
//  video_on     out  1   1 when h_count<H_ACTIVE and v_count<V_ACTIVE
//  line_tick    out  1   1 while h_count==H_TOTAL-1 and run=1
//  frame_tick   out  1   1 while h_count==H_TOTAL-1, v_count==V_TOTAL-1, run=1
//  upd_grant    out  1   update window open
//  upd_overrun  out  1   1-cycle pulse: grant revoked before upd_done
// BEHAVIOUR
//  Reset (async, d_reset_n=0): h/v_count=0, hsync=vsync=~SYNC_POL, video_on=0,
//   upd_grant=0, upd_overrun=0, FSM=IDLE, frame_granted=0. Ticks are 0 (run gated).
//  Counters: with run=1, h_count+1 per clock; at H_TOTAL-1 wraps to 0 and v_count+1
//   the same edge; v_count wraps V_TOTAL-1 -> 0 on that edge. Never exceed TOTAL-1.
//  run=0: counts, syncs, video_on, FSM hold; line/frame_tick forced 0.
//  hsync/vsync/video_on are registered and computed from next-count values, so they
//   correspond to the h/v_count shown in the same cycle (zero relative latency).
//  hsync asserted for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
//  vsync asserted for v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
//  Blank window B: V_ACTIVE <= v_count < V_TOTAL-GUARD_LINES (480..522 default).
//  Update FSM (advances only when run=1):
//   IDLE : upd_req=1 and frame_granted=0 -> WAIT.
//   WAIT : upd_req=0 -> IDLE. Else if next counts lie in B -> GRANT (upd_grant=1 on
//          the edge the counts enter/are in B; first possible grant h=0,v=480).
//   GRANT: upd_grant=1, frame_granted=1. upd_done=1 -> IDLE, grant 0 next cycle.
//          Next counts leave B (h=0,v=523) without done -> IDLE, grant 0 and
//          upd_overrun=1 for that one cycle. Done and leave-B same edge: done wins,
//          no overrun. upd_req dropping in GRANT is ignored; only done/revoke end it.
//  frame_granted cleared on frame_tick: at most one grant per frame.
//  upd_done outside GRANT ignored. Mid-operation reset aborts grant immediately (async).
// TESTING
//  Reset: hold d_reset_n=0 -> all outputs at reset values; release mid-cycle then run=1
//   -> h_count 0,1,2... with video_on=1 from first counted cycle.
//  Full frame: run=1 for 420000 clocks -> exactly 525 line_tick, 1 frame_tick,
//   307200 video_on cycles, counts back at (0,0); hsync low only h 656..751, vsync low
//   only v 490..491.
//  Freeze: drop run at h=799,v=524 for 10 clocks -> counts hold, no ticks; resume ->
//   next edge (0,0) and frame_tick seen exactly once.
//  Normal update: upd_req=1 at v=100 -> upd_grant rises with counts (0,480); upd_done
//   pulse at v=490 -> grant 0 next cycle; req held -> no second grant until next frame.
//  Overrun: upd_req=1, never done -> grant from (0,480) to (0,523) falls, overrun 1 cycle.
//  Reset mid-GRANT at v=500: d_reset_n=0 -> upd_grant=0 immediately, counts (0,0).

Source files
------------

// File: rtl/vga_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// vga_frame_sequencer_if
// Groups the run control, update handshake and timing outputs of
// vga_frame_sequencer. Clock and reset stay plain ports on the module.
//   run          game side -> sequencer : 1 = timing advances, 0 = freeze
//   upd_req      game side -> sequencer : request an update window (level)
//   upd_done     game side -> sequencer : update finished (1-cycle pulse)
//   h_count      sequencer -> game side : horizontal position
//   v_count      sequencer -> game side : vertical position
//   hsync/vsync  sequencer -> game side : sync outputs, SYNC_POL when asserted
//   video_on     sequencer -> game side : visible-area flag
//   line_tick    sequencer -> game side : last pixel of a line (run-gated)
//   frame_tick   sequencer -> game side : last pixel of a frame (run-gated)
//   upd_grant    sequencer -> game side : update window open
//   upd_overrun  sequencer -> game side : grant revoked before upd_done
// ---------------------------------------------------------------------------
interface vga_frame_sequencer_if;
  logic        run;
  logic        upd_req;
  logic        upd_done;
  logic [15:0] h_count;
  logic [15:0] v_count;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        line_tick;
  logic        frame_tick;
  logic        upd_grant;
  logic        upd_overrun;

  // Game logic / controller side.
  modport master (
    output run, upd_req, upd_done,
    input  h_count, v_count, hsync, vsync, video_on,
           line_tick, frame_tick, upd_grant, upd_overrun
  );

  // Sequencer side.
  modport slave (
    input  run, upd_req, upd_done,
    output h_count, v_count, hsync, vsync, video_on,
           line_tick, frame_tick, upd_grant, upd_overrun
  );
endinterface

// File: rtl/vga_frame_sequencer.sv
// ---------------------------------------------------------------------------
// vga_frame_sequencer
// VGA raster timing on the pixel clock (640x480@60 by default) plus an
// update-window arbiter that only lets game logic touch shared sprite/frame
// state during vertical blanking, at most once per frame.
// Ports:
//   clk_25Mhz  in  pixel clock, all logic on the rising edge
//   d_reset_n  in  asynchronous active-low reset
//   bus        vga_frame_sequencer_if.slave : run/update handshake inputs,
//              counters, syncs, video_on, ticks, grant/overrun outputs
// ---------------------------------------------------------------------------
module vga_frame_sequencer #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned GUARD_LINES = 2
) (
  input logic                  clk_25Mhz,
  input logic                  d_reset_n,
  vga_frame_sequencer_if.slave bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Exclusive upper bound of the update window: the last GUARD_LINES
  // blanking lines are kept free so state is settled before scan-out.
  localparam logic [15:0] BLANK_END = 16'(V_TOTAL - GUARD_LINES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT
  } upd_state_t;

  logic [15:0] h_count;
  logic [15:0] v_count;
  logic [15:0] h_next;
  logic [15:0] v_next;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        h_wrap;
  logic        next_in_blank;
  logic        line_tick;
  logic        frame_tick;
  logic        upd_grant;
  logic        upd_overrun;
  logic        frame_granted;
  upd_state_t  state;

  // Next raster position; everything registered below is decoded from it
  // so registered outputs line up with the count shown in the same cycle.
  always_comb begin
    h_wrap        = (h_count == H_LAST);
    h_next        = h_wrap ? '0 : h_count + 16'd1;
    v_next        = v_count;
    if (h_wrap) begin
      v_next = (v_count == V_LAST) ? '0 : v_count + 16'd1;
    end
    next_in_blank = (v_next >= V_VIS) && (v_next < BLANK_END);
    line_tick     = bus.run && h_wrap;
    frame_tick    = line_tick && (v_count == V_LAST);
  end

  // Raster counters and sync/visible decode.
  always_ff @(posedge clk_25Mhz or negedge d_reset_n) begin
    if (!d_reset_n) begin
      h_count  <= '0;
      v_count  <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b0;
    end else if (bus.run) begin
      h_count  <= h_next;
      v_count  <= v_next;
      hsync    <= ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync    <= ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      video_on <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  // Update-window arbiter. Grant opens on the edge the raster enters the
  // blank window and is revoked (with an overrun pulse) on the edge it
  // leaves; upd_done on that same edge takes priority and suppresses the
  // overrun. frame_granted limits the window to one grant per frame.
  always_ff @(posedge clk_25Mhz or negedge d_reset_n) begin
    if (!d_reset_n) begin
      state         <= S_IDLE;
      upd_grant     <= 1'b0;
      upd_overrun   <= 1'b0;
      frame_granted <= 1'b0;
    end else begin
      upd_overrun <= 1'b0;
      if (bus.run) begin
        if (frame_tick) begin
          frame_granted <= 1'b0;
        end
        unique case (state)
          S_IDLE: begin
            if (bus.upd_req && !frame_granted) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!bus.upd_req) begin
              state <= S_IDLE;
            end else if (next_in_blank) begin
              state         <= S_GRANT;
              upd_grant     <= 1'b1;
              frame_granted <= 1'b1;
            end
          end
          S_GRANT: begin
            if (bus.upd_done) begin
              state     <= S_IDLE;
              upd_grant <= 1'b0;
            end else if (!next_in_blank) begin
              state       <= S_IDLE;
              upd_grant   <= 1'b0;
              upd_overrun <= 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            upd_grant <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.h_count     = h_count;
  assign bus.v_count     = v_count;
  assign bus.hsync       = hsync;
  assign bus.vsync       = vsync;
  assign bus.video_on    = video_on;
  assign bus.line_tick   = line_tick;
  assign bus.frame_tick  = frame_tick;
  assign bus.upd_grant   = upd_grant;
  assign bus.upd_overrun = upd_overrun;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_sequencer
// Self-checking bench for vga_frame_sequencer using a reduced raster
// (24x18 totals, 16x10 visible) so whole frames fit in a short run.
// A position model pushes expected counts/syncs/video_on per clock into a
// scoreboard queue that is popped and compared on the falling edge; a
// vector table walks the update-window handshake; hand-written sequences
// cover full-frame totals, freeze at frame end and reset during a grant.
// ---------------------------------------------------------------------------
module tb_vga_frame_sequencer;

  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 10, VF = 2, VS = 2, VB = 4;
  localparam int unsigned GUARD = 2;
  localparam int unsigned HT = HA + HF + HS + HB;   // 24
  localparam int unsigned VT = VA + VF + VS + VB;   // 18
  localparam int unsigned FRAME = HT * VT;          // 432
  localparam int unsigned NVEC = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_frame_sequencer_if bus();

  vga_frame_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .GUARD_LINES(GUARD)
  ) dut (
    .clk_25Mhz(clk),
    .d_reset_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- position model + scoreboard ----------------
  typedef struct {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        von;
  } exp_t;

  exp_t sb[$];
  int unsigned pos = 0;
  bit moved = 1'b0;
  int unsigned tot_line = 0, tot_frame = 0, tot_von = 0;

  function automatic exp_t model(input int unsigned p, input bit mv);
    exp_t e;
    int unsigned h, v;
    h = p % HT;
    v = p / HT;
    e.h   = 16'(h);
    e.v   = 16'(v);
    e.hs  = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
    e.vs  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
    e.von = mv && (h < HA) && (v < VA);
    return e;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pos = 0;
      moved = 1'b0;
      sb.delete();
    end else begin
      if (bus.run) begin
        pos = (pos + 1) % FRAME;
        moved = 1'b1;
      end
      sb.push_back(model(pos, moved));
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb h_count", 32'(bus.h_count), 32'(e.h));
        check("sb v_count", 32'(bus.v_count), 32'(e.v));
        check("sb hsync", 32'(bus.hsync), 32'(e.hs));
        check("sb vsync", 32'(bus.vsync), 32'(e.vs));
        check("sb video_on", 32'(bus.video_on), 32'(e.von));
        check("sb line_tick", 32'(bus.line_tick), 32'(bus.run && (e.h == 16'(HT - 1))));
        check("sb frame_tick", 32'(bus.frame_tick),
              32'(bus.run && (e.h == 16'(HT - 1)) && (e.v == 16'(VT - 1))));
      end
      if (bus.line_tick) tot_line++;
      if (bus.frame_tick) tot_frame++;
      if (bus.video_on) tot_von++;
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int unsigned run, req, done, n;
    int unsigned h, v, g, ov, von;
  } vec_t;

  vec_t tbl[NVEC];

  task automatic nwait();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int unsigned k;
    int unsigned s_line, s_frame, s_von;

    //            run req done  n     h   v  g ov von
    tbl[0]  = '{1, 0, 0,   1,    1,  0, 0, 0, 1};
    tbl[1]  = '{1, 0, 0,   99,   4,  4, 0, 0, 1};
    tbl[2]  = '{1, 1, 1,   139, 23,  9, 0, 0, 0};
    tbl[3]  = '{1, 1, 0,   1,    0, 10, 1, 0, 0};
    tbl[4]  = '{0, 1, 0,   5,    0, 10, 1, 0, 0};
    tbl[5]  = '{1, 0, 0,   20,  20, 10, 1, 0, 0};
    tbl[6]  = '{1, 0, 1,   1,   21, 10, 0, 0, 0};
    tbl[7]  = '{1, 1, 0,   170, 23, 17, 0, 0, 0};
    tbl[8]  = '{1, 1, 0,   1,    0,  0, 0, 0, 1};
    tbl[9]  = '{1, 1, 0,   240,  0, 10, 1, 0, 0};
    tbl[10] = '{1, 1, 0,   143, 23, 15, 1, 0, 0};
    tbl[11] = '{1, 1, 0,   1,    0, 16, 0, 1, 0};
    tbl[12] = '{1, 1, 0,   1,    1, 16, 0, 0, 0};
    tbl[13] = '{1, 1, 0,   286, 23,  9, 0, 0, 0};
    tbl[14] = '{1, 1, 0,   1,    0, 10, 1, 0, 0};
    tbl[15] = '{1, 1, 0,   143, 23, 15, 1, 0, 0};
    tbl[16] = '{1, 1, 1,   1,    0, 16, 0, 0, 0};
    tbl[17] = '{1, 1, 0,   1,    1, 16, 0, 0, 0};

    bus.run = 1'b0;
    bus.upd_req = 1'b0;
    bus.upd_done = 1'b0;

    // Held in reset: outputs at reset values.
    repeat (2) nwait();
    check("rst h_count", 32'(bus.h_count), 0);
    check("rst v_count", 32'(bus.v_count), 0);
    check("rst hsync", 32'(bus.hsync), 1);
    check("rst vsync", 32'(bus.vsync), 1);
    check("rst video_on", 32'(bus.video_on), 0);
    check("rst grant", 32'(bus.upd_grant), 0);
    check("rst overrun", 32'(bus.upd_overrun), 0);
    rst_n = 1'b1;  // released mid-cycle

    for (int i = 0; i < int'(NVEC); i++) begin
      bus.run = (tbl[i].run != 0);
      bus.upd_req = (tbl[i].req != 0);
      bus.upd_done = (tbl[i].done != 0);
      repeat (tbl[i].n) nwait();
      check($sformatf("vec%0d h_count", i), 32'(bus.h_count), tbl[i].h);
      check($sformatf("vec%0d v_count", i), 32'(bus.v_count), tbl[i].v);
      check($sformatf("vec%0d grant", i), 32'(bus.upd_grant), tbl[i].g);
      check($sformatf("vec%0d overrun", i), 32'(bus.upd_overrun), tbl[i].ov);
      check($sformatf("vec%0d video_on", i), 32'(bus.video_on), tbl[i].von);
    end

    // Full frame from (1,16): totals over exactly one frame period.
    bus.run = 1'b1;
    bus.upd_req = 1'b0;
    bus.upd_done = 1'b0;
    s_line = tot_line; s_frame = tot_frame; s_von = tot_von;
    repeat (FRAME) nwait();
    check("frame line_ticks", tot_line - s_line, VT);
    check("frame frame_ticks", tot_frame - s_frame, 1);
    check("frame video_on cycles", tot_von - s_von, HA * VA);
    check("frame end h_count", 32'(bus.h_count), 1);
    check("frame end v_count", 32'(bus.v_count), 16);

    // Freeze on the last pixel of the frame.
    k = 0;
    while (!(bus.h_count == 16'(HT - 2) && bus.v_count == 16'(VT - 1)) && k < 2 * FRAME) begin
      nwait();
      k++;
    end
    check("seek pre-frame-end", 32'(k < 2 * FRAME), 1);
    s_line = tot_line; s_frame = tot_frame;
    nwait();                       // now at (23,17) with run=1: tick seen here
    bus.run = 1'b0;
    repeat (10) nwait();
    check("freeze h_count", 32'(bus.h_count), HT - 1);
    check("freeze v_count", 32'(bus.v_count), VT - 1);
    check("freeze frame_ticks", tot_frame - s_frame, 1);
    bus.run = 1'b1;
    bus.upd_req = 1'b1;
    nwait();
    check("resume h_count", 32'(bus.h_count), 0);
    check("resume v_count", 32'(bus.v_count), 0);
    check("resume frame_ticks", tot_frame - s_frame, 1);
    check("resume line_ticks", tot_line - s_line, 1);

    // Reset while granted, deep inside the blank window.
    k = 0;
    while (!(bus.h_count == 16'd0 && bus.v_count == 16'd13) && k < 2 * FRAME) begin
      nwait();
      k++;
    end
    check("seek grant line", 32'(k < 2 * FRAME), 1);
    check("grant held v13", 32'(bus.upd_grant), 1);
    check("vsync asserted v13", 32'(bus.vsync), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst grant", 32'(bus.upd_grant), 0);
    check("async rst h_count", 32'(bus.h_count), 0);
    check("async rst v_count", 32'(bus.v_count), 0);
    check("async rst vsync", 32'(bus.vsync), 1);
    check("async rst overrun", 32'(bus.upd_overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
